config_port_arbiter: RTL and testbench

- Arbitrates the single 32-bit configuration write path into ConfigFSM between NUM_SRC configuration sources: index 0 CPU self-write, index 1 bitbang, index 2 UART.
- Replaces the combinational priority muxing with an ownership-locked arbiter: a source owns the port for its whole bitstream.
- Emits a one-cycle FSM_Reset on each ownership change.
- Counts writes that are dropped from non-owners.

---
 rtl/cfg_arb_pkg.sv | 16 +
 rtl/cfg_prio_select.sv | 22 ++
 rtl/config_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_config_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_arb_pkg.sv
// Shared definitions for the configuration port arbiter.
//   arb_state_e : arbiter FSM state encoding
//   SRC_*       : source index assignment (higher index = higher priority)
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_OWNED  = 2'd2
    } arb_state_e;

    localparam int SRC_CPU     = 0;
    localparam int SRC_BITBANG = 1;
    localparam int SRC_UART    = 2;

endpackage

// File: rtl/cfg_prio_select.sv
// Highest-index-wins one-hot picker.
//   req : request vector
//   gnt : one-hot of the highest set bit of req, all zero when req is zero
module cfg_prio_select #(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt
);

    always_comb begin
        gnt = '0;
        // Later iterations overwrite earlier ones, so the highest index wins.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Ownership-locked arbiter for the single configuration write path into
// ConfigFSM. A source owns the port for its whole session; ownership is
// released after the owner's active line stays low for IDLE_TIMEOUT cycles.
//
// Ports:
//   CLK, reset          : clock, async active-high reset
//   src_active          : per-source session-active level
//   src_strobe          : per-source single-cycle write strobe
//   src_data            : per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   drop_clear          : synchronous clear of drop_count (wins over increment)
//   ConfigWriteData     : registered write data to ConfigFSM
//   ConfigWriteStrobe   : registered write strobe to ConfigFSM
//   FSM_Reset           : one-cycle pulse on each grant to a new owner
//   grant               : one-hot current owner, zero when unowned
//   busy                : high when any source owns the port
//   drop_count          : saturating count of strobes that were not forwarded
//
// Build option:
//   CONFIG_ARB_PREEMPT_EN : a higher-index active source takes ownership from
//                           the current owner (through SWITCH). Undefined means
//                           ownership is strictly non-preemptive.
//
// State table:
//   state  | meaning
//   IDLE   | no owner; pick highest active source, go to SWITCH
//   SWITCH | one cycle, FSM_Reset high, all strobes dropped
//   OWNED  | owner strobes forwarded, idle timer runs while owner inactive
module config_port_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int IDLE_TIMEOUT = 16,
    parameter int TO_WIDTH     = 5,
    parameter int DROP_WIDTH   = 8
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_active,
    input  logic [NUM_SRC-1:0]            src_strobe,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic                          drop_clear,
    output logic [DATA_WIDTH-1:0]         ConfigWriteData,
    output logic                          ConfigWriteStrobe,
    output logic                          FSM_Reset,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy,
    output logic [DROP_WIDTH-1:0]         drop_count
);

    localparam int CNT_W = $clog2(NUM_SRC + 1);

    arb_state_e              state_q, state_d;
    logic [NUM_SRC-1:0]      grant_q, grant_d;
    logic [TO_WIDTH-1:0]     idle_cnt_q, idle_cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    strobe_q, strobe_d;
    logic                    fsm_reset_q, fsm_reset_d;
    logic [DROP_WIDTH-1:0]   drop_q, drop_d;

    logic [NUM_SRC-1:0]      sel_gnt;
    logic [NUM_SRC-1:0]      drop_mask;
    logic [CNT_W-1:0]        drop_inc;
    logic [DROP_WIDTH:0]     drop_sum;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    owner_strobe;
    logic                    owner_active;
    logic [TO_WIDTH-1:0]     idle_inc;

    cfg_prio_select #(.NUM_SRC(NUM_SRC)) u_sel (
        .req (src_active),
        .gnt (sel_gnt)
    );

`ifdef CONFIG_ARB_PREEMPT_EN
    logic [NUM_SRC-1:0] higher_req;
    logic [NUM_SRC-1:0] pre_gnt;

    // Active requests strictly above the current owner's index.
    always_comb begin
        logic above;
        above      = 1'b0;
        higher_req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (above) higher_req[i] = src_active[i];
            if (grant_q[i]) above = 1'b1;
        end
    end

    cfg_prio_select #(.NUM_SRC(NUM_SRC)) u_pre_sel (
        .req (higher_req),
        .gnt (pre_gnt)
    );
`endif

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) owner_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner_strobe = |(src_strobe & grant_q);
    assign owner_active = |(src_active & grant_q);
    assign idle_inc     = idle_cnt_q + TO_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idle_cnt_d  = idle_cnt_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        fsm_reset_d = 1'b0;
        drop_mask   = '0;

        case (state_q)
            ST_IDLE: begin
                drop_mask = src_strobe;
                if (|src_active) begin
                    grant_d     = sel_gnt;
                    state_d     = ST_SWITCH;
                    fsm_reset_d = 1'b1;
                    idle_cnt_d  = '0;
                end
            end
            ST_SWITCH: begin
                drop_mask = src_strobe;
                state_d   = ST_OWNED;
            end
            ST_OWNED: begin
                drop_mask = src_strobe & ~grant_q;
                if (owner_strobe) begin
                    strobe_d = 1'b1;
                    data_d   = owner_data;
                end
                if (owner_active) begin
                    idle_cnt_d = '0;
                end else if (idle_inc == TO_WIDTH'(IDLE_TIMEOUT)) begin
                    // Quiet release: no FSM_Reset, new owner picked next cycle.
                    grant_d    = '0;
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_inc;
                end
`ifdef CONFIG_ARB_PREEMPT_EN
                if (|higher_req) begin
                    grant_d     = pre_gnt;
                    state_d     = ST_SWITCH;
                    fsm_reset_d = 1'b1;
                    idle_cnt_d  = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_inc = drop_inc + CNT_W'(drop_mask[i]);
        end
        drop_sum = {1'b0, drop_q} + (DROP_WIDTH+1)'(drop_inc);
        if (drop_clear) begin
            drop_d = '0;
        end else if (drop_sum[DROP_WIDTH]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            idle_cnt_q  <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            fsm_reset_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idle_cnt_q  <= idle_cnt_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            fsm_reset_q <= fsm_reset_d;
            drop_q      <= drop_d;
        end
    end

    assign ConfigWriteData   = data_q;
    assign ConfigWriteStrobe = strobe_q;
    assign FSM_Reset         = fsm_reset_q;
    assign grant             = grant_q;
    assign busy              = (state_q != ST_IDLE);
    assign drop_count        = drop_q;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed testbench for config_port_arbiter (default parameters).
module tb_config_port_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic [2:0]  src_active;
    logic [2:0]  src_strobe;
    logic [95:0] src_data;
    logic        drop_clear;
    logic [31:0] ConfigWriteData;
    logic        ConfigWriteStrobe;
    logic        FSM_Reset;
    logic [2:0]  grant;
    logic        busy;
    logic [7:0]  drop_count;

    int vectors    = 0;
    int miscompares = 0;

    config_port_arbiter dut (
        .CLK               (CLK),
        .reset             (reset),
        .src_active        (src_active),
        .src_strobe        (src_strobe),
        .src_data          (src_data),
        .drop_clear        (drop_clear),
        .ConfigWriteData   (ConfigWriteData),
        .ConfigWriteStrobe (ConfigWriteStrobe),
        .FSM_Reset         (FSM_Reset),
        .grant             (grant),
        .busy              (busy),
        .drop_count        (drop_count)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        src_active = '0;
        src_strobe = '0;
        src_data   = '0;
        drop_clear = 1'b0;
        reset      = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Acquire ownership for a single source: IDLE -> SWITCH -> OWNED.
    task automatic own(input logic [2:0] mask);
        src_active = mask;
        step(2);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({grant, busy, FSM_Reset, ConfigWriteStrobe} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {grant, busy, FSM_Reset, ConfigWriteStrobe});
        end
        vectors++;
        if ({ConfigWriteData, drop_count} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {ConfigWriteData, drop_count});
        end
    endtask

    task automatic test_uart_grant();
        do_reset();
        src_active = 3'b100;
        step(1);
        vectors++;
        if ({grant, FSM_Reset, busy} !== {3'b100, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL uart_switch got %b want 10011", {grant, FSM_Reset, busy});
        end
        step(1);
        vectors++;
        if ({grant, FSM_Reset} !== {3'b100, 1'b0}) begin
            miscompares++;
            $display("FAIL uart_owned got %b want 1000", {grant, FSM_Reset});
        end
        src_data[64 +: 32] = 32'hDEADBEEF;
        src_strobe = 3'b100;
        #1;
        vectors++;
        if (ConfigWriteStrobe !== 1'b0) begin
            miscompares++;
            $display("FAIL uart_latency got %b want 0", ConfigWriteStrobe);
        end
        step(1);
        src_strobe = 3'b000;
        vectors++;
        if ({ConfigWriteStrobe, ConfigWriteData} !== {1'b1, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL uart_fwd got %b/%h want 1/deadbeef", ConfigWriteStrobe, ConfigWriteData);
        end
        src_data[64 +: 32] = 32'h12345678;
        step(1);
        vectors++;
        if ({ConfigWriteStrobe, ConfigWriteData, drop_count} !== {1'b0, 32'hDEADBEEF, 8'd0}) begin
            miscompares++;
            $display("FAIL uart_hold got %b/%h/%0d want 0/deadbeef/0",
                     ConfigWriteStrobe, ConfigWriteData, drop_count);
        end
    endtask

    task automatic test_switch_drop();
        do_reset();
        src_data[32 +: 32] = 32'hA5A5_0001;
        src_active = 3'b010;
        src_strobe = 3'b010;
        step(1);
        vectors++;
        if ({ConfigWriteStrobe, drop_count} !== {1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL idle_drop got %b/%0d want 0/1", ConfigWriteStrobe, drop_count);
        end
        step(1);
        vectors++;
        if ({ConfigWriteStrobe, drop_count} !== {1'b0, 8'd2}) begin
            miscompares++;
            $display("FAIL switch_drop got %b/%0d want 0/2", ConfigWriteStrobe, drop_count);
        end
        src_strobe = 3'b011;
        step(1);
        src_strobe = 3'b000;
        vectors++;
        if ({ConfigWriteStrobe, ConfigWriteData, drop_count} !== {1'b1, 32'hA5A5_0001, 8'd3}) begin
            miscompares++;
            $display("FAIL owned_mix got %b/%h/%0d want 1/a5a50001/3",
                     ConfigWriteStrobe, ConfigWriteData, drop_count);
        end
    endtask

    task automatic test_drop_count();
        do_reset();
        own(3'b010);
        src_data[0 +: 32] = 32'hC0DE_0000;
        for (int k = 0; k < 5; k++) begin
            src_strobe = 3'b001;
            step(1);
            vectors++;
            if (ConfigWriteStrobe !== 1'b0) begin
                miscompares++;
                $display("FAIL cpu_blocked[%0d] got %b want 0", k, ConfigWriteStrobe);
            end
        end
        vectors++;
        if (drop_count !== 8'd5) begin
            miscompares++;
            $display("FAIL drop5 got %0d want 5", drop_count);
        end
        drop_clear = 1'b1;
        step(1);
        drop_clear = 1'b0;
        src_strobe = 3'b000;
        vectors++;
        if (drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL drop_clear got %0d want 0", drop_count);
        end
        src_strobe = 3'b101;
        step(1);
        src_strobe = 3'b000;
        vectors++;
        if ({drop_count, ConfigWriteStrobe} !== {8'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_multi got %0d/%b want 2/0", drop_count, ConfigWriteStrobe);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        own(3'b010);
        for (int k = 0; k < 3; k++) begin
            src_data[32 +: 32] = 32'h100 + k;
            src_strobe = 3'b010;
            step(1);
            vectors++;
            if ({ConfigWriteStrobe, ConfigWriteData} !== {1'b1, 32'h100 + k}) begin
                miscompares++;
                $display("FAIL b2b[%0d] got %b/%h want 1/%h", k, ConfigWriteStrobe,
                         ConfigWriteData, 32'h100 + k);
            end
        end
        src_strobe = 3'b000;
        step(1);
        vectors++;
        if (ConfigWriteStrobe !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end got %b want 0", ConfigWriteStrobe);
        end
    endtask

    task automatic test_idle_timeout();
        do_reset();
        own(3'b010);
        src_active = 3'b000;
        step(10);
        vectors++;
        if ({grant, busy, FSM_Reset} !== {3'b010, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL idle10 got %b want 01010", {grant, busy, FSM_Reset});
        end
        src_active = 3'b010;
        step(1);
        vectors++;
        if ({grant, FSM_Reset} !== {3'b010, 1'b0}) begin
            miscompares++;
            $display("FAIL reactivate got %b want 0100", {grant, FSM_Reset});
        end
        src_active = 3'b000;
        step(4);
        src_data[32 +: 32] = 32'h0000_BEEF;
        src_strobe = 3'b010;
        step(1);
        src_strobe = 3'b000;
        vectors++;
        if ({ConfigWriteStrobe, ConfigWriteData} !== {1'b1, 32'h0000_BEEF}) begin
            miscompares++;
            $display("FAIL countdown_fwd got %b/%h want 1/0000beef", ConfigWriteStrobe, ConfigWriteData);
        end
        step(10);
        vectors++;
        if ({grant, busy} !== {3'b010, 1'b1}) begin
            miscompares++;
            $display("FAIL idle15 got %b want 0101", {grant, busy});
        end
        src_active = 3'b001;
        step(1);
        vectors++;
        if ({grant, busy, FSM_Reset} !== 5'b00000) begin
            miscompares++;
            $display("FAIL idle16 got %b want 00000", {grant, busy, FSM_Reset});
        end
        step(1);
        vectors++;
        if ({grant, busy, FSM_Reset} !== {3'b001, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL reselect got %b want 00111", {grant, busy, FSM_Reset});
        end
    endtask

    task automatic test_preempt();
        logic [2:0] exp_grant;
        logic       exp_fsm_reset;
`ifdef CONFIG_ARB_PREEMPT_EN
        exp_grant     = 3'b100;
        exp_fsm_reset = 1'b1;
`else
        exp_grant     = 3'b010;
        exp_fsm_reset = 1'b0;
`endif
        do_reset();
        own(3'b010);
        src_data[32 +: 32] = 32'h0BB0_0BB0;
        src_active = 3'b110;
        src_strobe = 3'b010;
        step(1);
        src_strobe = 3'b000;
        vectors++;
        if ({grant, FSM_Reset, ConfigWriteStrobe} !== {exp_grant, exp_fsm_reset, 1'b1}) begin
            miscompares++;
            $display("FAIL preempt got %b want %b", {grant, FSM_Reset, ConfigWriteStrobe},
                     {exp_grant, exp_fsm_reset, 1'b1});
        end
        step(1);
        vectors++;
        if ({grant, FSM_Reset} !== {exp_grant, 1'b0}) begin
            miscompares++;
            $display("FAIL preempt_after got %b want %b", {grant, FSM_Reset}, {exp_grant, 1'b0});
        end
    endtask

    task automatic test_saturate();
        do_reset();
        own(3'b010);
        src_strobe = 3'b001;
        step(255);
        vectors++;
        if (drop_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat255 got %0d want 255", drop_count);
        end
        step(45);
        src_strobe = 3'b000;
        vectors++;
        if (drop_count !== 8'd255) begin
            miscompares++;
            $display("FAIL sat300 got %0d want 255", drop_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        own(3'b010);
        src_data[32 +: 32] = 32'h7777_7777;
        src_strobe = 3'b110;
        step(1);
        vectors++;
        if ({ConfigWriteStrobe, drop_count} !== {1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL pre_reset got %b/%0d want 1/1", ConfigWriteStrobe, drop_count);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({ConfigWriteStrobe, grant, busy, FSM_Reset, drop_count, ConfigWriteData} !== 46'h0) begin
            miscompares++;
            $display("FAIL async_reset got %b/%b/%b/%b/%0d/%h want all zero",
                     ConfigWriteStrobe, grant, busy, FSM_Reset, drop_count, ConfigWriteData);
        end
        src_strobe = 3'b000;
        src_active = 3'b000;
        step(1);
        reset = 1'b0;
        step(1);
        vectors++;
        if ({grant, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset got %b want 0000", {grant, busy});
        end
    endtask

    initial begin
        test_reset();
        test_uart_grant();
        test_switch_drop();
        test_drop_count();
        test_back_to_back();
        test_idle_timeout();
        test_preempt();
        test_saturate();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
